// File: rtl/dmem_bus_ctrl_pkg.sv
// Shared types and constants for the data-memory bus controller.
// Holds the FSM encoding, the default timeout and error data, and word-address helpers.
package dmem_bus_ctrl_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned TIMEOUT_DEF  = 16;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
    localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD      = 2'd2,
        ST_RD_DONE = 2'd3
    } state_e;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
        return a & WORD_MASK;
    endfunction

    function automatic logic is_aligned(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_bus_ctrl_wbuf.sv
// One-entry posted-write buffer: valid/addr/data with load, clear and address match.
// A same-edge load wins over clear so the buffer can be drained and refilled at once.
module dmem_bus_ctrl_wbuf
    import dmem_bus_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] cmp_addr,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              hit
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            addr_d  = ld_addr;
            data_d  = ld_data;
        end else if (clr) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload is only observed while valid_q is set, so it carries no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign valid = valid_q;
    assign addr  = addr_q;
    assign data  = data_q;
    assign hit   = valid_q && (addr_q == word_addr(cmp_addr));

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-memory port controller: turns single-cycle MEM-stage accesses into req/ack bus
// transactions with a posted write buffer, read stalls, a bus timeout and sticky error flags.
module dmem_bus_ctrl
    import dmem_bus_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              err_clr,
    output logic              bus_err,
    output logic              align_err
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              bus_err_q, bus_err_d;
    logic              align_err_q, align_err_d;

    logic              aligned, misaligned, rd_ok, wr_ok;
    logic              busy, timed_out, read_miss;
    logic              wbuf_valid, wbuf_hit, wbuf_free, wbuf_load, wbuf_clr;
    logic [ADDR_W-1:0] wbuf_addr;
    logic [DATA_W-1:0] wbuf_data;

    dmem_bus_ctrl_wbuf u_wbuf (
        .clk      (clk),
        .rst      (rst),
        .load     (wbuf_load),
        .clr      (wbuf_clr),
        .ld_addr  (word_addr(cpu_addr)),
        .ld_data  (cpu_wdata),
        .cmp_addr (cpu_addr),
        .valid    (wbuf_valid),
        .addr     (wbuf_addr),
        .data     (wbuf_data),
        .hit      (wbuf_hit)
    );

    always_comb begin
        aligned    = is_aligned(cpu_addr);
        misaligned = (cpu_rd || cpu_wr) && !aligned;
        rd_ok      = cpu_rd && aligned;
        wr_ok      = cpu_wr && aligned;
        busy       = (state_q == ST_WR) || (state_q == ST_RD);
        timed_out  = busy && !bus_ack && (cnt_q == CNT_LAST);
        // In RD_DONE the pending load is being answered from the read latch, not re-issued.
        read_miss  = rd_ok && !wbuf_hit && (state_q != ST_RD_DONE);
        wbuf_free  = !wbuf_valid || ((state_q == ST_WR) && bus_ack);
        wbuf_load  = wr_ok && wbuf_free;
        wbuf_clr   = (state_q == ST_WR) && (bus_ack || timed_out);
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (read_miss && !wbuf_valid) begin
                    state_d = ST_RD;
                end else if (wbuf_valid || wbuf_load) begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (bus_ack || timed_out) state_d = ST_IDLE;
            end
            ST_RD: begin
                if (bus_ack || timed_out) state_d = ST_RD_DONE;
            end
            ST_RD_DONE: begin
                state_d = wbuf_valid ? ST_WR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus_req   = (state_q == ST_WR) || (state_q == ST_RD);
        cpu_stall = read_miss || (wr_ok && !wbuf_free);
        cpu_rdata = '0;
        if ((state_q == ST_RD_DONE) && !misaligned) begin
            cpu_rdata = rdata_q;
        end else if (rd_ok && wbuf_hit) begin
            cpu_rdata = wbuf_data;
        end
    end

    // Bus address/data are captured only on entry to WR/RD so they stay stable under req.
    always_comb begin
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if ((state_d == ST_WR) && (state_q != ST_WR)) begin
            bus_we_d    = 1'b1;
            bus_addr_d  = wbuf_valid ? wbuf_addr : word_addr(cpu_addr);
            bus_wdata_d = wbuf_valid ? wbuf_data : cpu_wdata;
        end else if ((state_d == ST_RD) && (state_q != ST_RD)) begin
            bus_we_d    = 1'b0;
            bus_addr_d  = word_addr(cpu_addr);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((state_d == ST_WR || state_d == ST_RD) && (state_d != state_q)) begin
            cnt_d = '0;
        end else if (busy) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (state_q == ST_RD) begin
            if (bus_ack) begin
                rdata_d = bus_rdata;
            end else if (timed_out) begin
                rdata_d = ERR_DATA;
            end
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_comb begin
        bus_err_d   = bus_err_q;
        align_err_d = align_err_q;
        if (timed_out)    bus_err_d = 1'b1;
        else if (err_clr) bus_err_d = 1'b0;
        if (misaligned)   align_err_d = 1'b1;
        else if (err_clr) align_err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            rdata_q     <= '0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_err_q   <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_err_q   <= bus_err_d;
            align_err_q <= align_err_d;
        end
    end

    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_err   = bus_err_q;
    assign align_err = align_err_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed bench for dmem_bus_ctrl: posted writes, reads with wait states, buffer hits,
// drain ordering, timeout, misalignment and asynchronous reset.
module tb_dmem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        err_clr = 1'b0;
    logic        bus_err;
    logic        align_err;

    int vec_cnt = 0;
    int err_cnt = 0;

    dmem_bus_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .err_clr   (err_clr),
        .bus_err   (bus_err),
        .align_err (align_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_rd  = 1'b0;
        cpu_wr  = 1'b0;
        bus_ack = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cpu_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec_cnt++; if (bus_req !== 1'b0)    begin err_cnt++; $display("FAIL rst_req: got %b want 0", bus_req); end
        vec_cnt++; if (bus_we !== 1'b0)     begin err_cnt++; $display("FAIL rst_we: got %b want 0", bus_we); end
        vec_cnt++; if (bus_addr !== 32'h0)  begin err_cnt++; $display("FAIL rst_addr: got %h want 0", bus_addr); end
        vec_cnt++; if (bus_wdata !== 32'h0) begin err_cnt++; $display("FAIL rst_wdata: got %h want 0", bus_wdata); end
        vec_cnt++; if (cpu_rdata !== 32'h0) begin err_cnt++; $display("FAIL rst_rdata: got %h want 0", cpu_rdata); end
        vec_cnt++; if (cpu_stall !== 1'b0)  begin err_cnt++; $display("FAIL rst_stall: got %b want 0", cpu_stall); end
        vec_cnt++; if (bus_err !== 1'b0 || align_err !== 1'b0)
            begin err_cnt++; $display("FAIL rst_errs: got %b%b want 00", bus_err, align_err); end
        cyc();
        rst = 1'b1;
        cyc();
    endtask

    // sw 0x10 <- 0x1234, acked in the first request cycle
    task automatic test_posted_write();
        cpu_wr = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1234;
        @(negedge clk);
        vec_cnt++; if (cpu_stall !== 1'b0) begin err_cnt++; $display("FAIL pw_stall0: got %b want 0", cpu_stall); end
        vec_cnt++; if (bus_req !== 1'b0)   begin err_cnt++; $display("FAIL pw_req0: got %b want 0", bus_req); end
        cyc();
        cpu_wr = 1'b0; bus_ack = 1'b1;
        @(negedge clk);
        vec_cnt++; if (bus_req !== 1'b1)     begin err_cnt++; $display("FAIL pw_req1: got %b want 1", bus_req); end
        vec_cnt++; if (bus_we !== 1'b1)      begin err_cnt++; $display("FAIL pw_we: got %b want 1", bus_we); end
        vec_cnt++; if (bus_addr !== 32'h10)  begin err_cnt++; $display("FAIL pw_addr: got %h want 10", bus_addr); end
        vec_cnt++; if (bus_wdata !== 32'h1234) begin err_cnt++; $display("FAIL pw_wdata: got %h want 1234", bus_wdata); end
        vec_cnt++; if (cpu_stall !== 1'b0)   begin err_cnt++; $display("FAIL pw_stall1: got %b want 0", cpu_stall); end
        cyc();
        bus_ack = 1'b0;
        @(negedge clk);
        vec_cnt++; if (bus_req !== 1'b0) begin err_cnt++; $display("FAIL pw_req_drop: got %b want 0", bus_req); end
        cyc();
    endtask

    // lw 0x20, ack in the third request cycle: 4 stall cycles
    task automatic test_read_wait();
        int stall_n = 0;
        int req_n = 0;
        logic done = 1'b0;
        cpu_rd = 1'b1; cpu_addr = 32'h20; bus_rdata = 32'hCAFE_0020;
        for (int i = 0; i < 30 && !done; i++) begin
            if (i > 0) begin
                cyc();
                if (bus_req) req_n++;
                bus_ack = bus_req && (req_n == 3);
            end
            @(negedge clk);
            if (cpu_stall) stall_n++;
            else done = 1'b1;
        end
        vec_cnt++; if (done !== 1'b1)   begin err_cnt++; $display("FAIL rd_done: stall never released"); end
        vec_cnt++; if (stall_n != 4)    begin err_cnt++; $display("FAIL rd_stall_cycles: got %0d want 4", stall_n); end
        vec_cnt++; if (cpu_rdata !== 32'hCAFE_0020) begin err_cnt++; $display("FAIL rd_data: got %h want cafe0020", cpu_rdata); end
        vec_cnt++; if (bus_we !== 1'b0 || bus_addr !== 32'h20)
            begin err_cnt++; $display("FAIL rd_bus: got we=%b addr=%h want we=0 addr=20", bus_we, bus_addr); end
        vec_cnt++; if (bus_req !== 1'b0) begin err_cnt++; $display("FAIL rd_req_drop: got %b want 0", bus_req); end
        cyc();
        cpu_idle();
        cyc();
    endtask

    // sw 0x40 <- 0xAA then lw 0x40 while the write is still pending
    task automatic test_wbuf_hit();
        cpu_wr = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hAA;
        cyc();
        cpu_wr = 1'b0; cpu_rd = 1'b1;
        @(negedge clk);
        vec_cnt++; if (cpu_stall !== 1'b0)   begin err_cnt++; $display("FAIL hit_stall: got %b want 0", cpu_stall); end
        vec_cnt++; if (cpu_rdata !== 32'hAA) begin err_cnt++; $display("FAIL hit_data: got %h want aa", cpu_rdata); end
        vec_cnt++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h40)
            begin err_cnt++; $display("FAIL hit_bus: got req=%b we=%b addr=%h want 1 1 40", bus_req, bus_we, bus_addr); end
        cyc();
        cpu_rd = 1'b0; bus_ack = 1'b1;
        cyc();
        bus_ack = 1'b0;
        @(negedge clk);
        vec_cnt++; if (bus_req !== 1'b0) begin err_cnt++; $display("FAIL hit_no_read: got req=%b want 0", bus_req); end
        cyc();
    endtask

    // sw 0x40 then lw 0x44: write pulse, gap, read pulse
    task automatic test_back_to_back();
        logic        pw [2];
        logic [31:0] pa [2];
        int   pulses = 0;
        int   stall_n = 0;
        logic prev_req = 1'b0;
        logic done = 1'b0;
        cpu_wr = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h55; bus_rdata = 32'h4444_0044;
        @(negedge clk);
        for (int i = 0; i < 20 && !done; i++) begin
            cyc();
            if (i == 0) begin cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 32'h44; end
            bus_ack = bus_req;
            if (bus_req && !prev_req) begin
                if (pulses < 2) begin pw[pulses] = bus_we; pa[pulses] = bus_addr; end
                pulses++;
            end
            prev_req = bus_req;
            @(negedge clk);
            if (cpu_stall) stall_n++;
            else done = 1'b1;
        end
        vec_cnt++; if (pulses != 2) begin err_cnt++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
        if (pulses >= 2) begin
            vec_cnt++; if (pw[0] !== 1'b1 || pa[0] !== 32'h40)
                begin err_cnt++; $display("FAIL b2b_first: got we=%b addr=%h want 1 40", pw[0], pa[0]); end
            vec_cnt++; if (pw[1] !== 1'b0 || pa[1] !== 32'h44)
                begin err_cnt++; $display("FAIL b2b_second: got we=%b addr=%h want 0 44", pw[1], pa[1]); end
        end
        vec_cnt++; if (stall_n != 3) begin err_cnt++; $display("FAIL b2b_stall: got %0d want 3", stall_n); end
        vec_cnt++; if (cpu_rdata !== 32'h4444_0044) begin err_cnt++; $display("FAIL b2b_data: got %h want 44440044", cpu_rdata); end
        cyc();
        cpu_idle();
        cyc();
    endtask

    // Buffer full: stall without ack, same-edge drain and refill with ack
    task automatic test_full_refill();
        cpu_wr = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'hA;
        cyc();
        cpu_addr = 32'h104; cpu_wdata = 32'hB;
        @(negedge clk);
        vec_cnt++; if (cpu_stall !== 1'b1) begin err_cnt++; $display("FAIL full_stall: got %b want 1", cpu_stall); end
        cyc();
        bus_ack = 1'b1;
        @(negedge clk);
        vec_cnt++; if (cpu_stall !== 1'b0) begin err_cnt++; $display("FAIL refill_stall: got %b want 0", cpu_stall); end
        vec_cnt++; if (bus_addr !== 32'h100 || bus_wdata !== 32'hA)
            begin err_cnt++; $display("FAIL refill_stable: got %h/%h want 100/a", bus_addr, bus_wdata); end
        cyc();
        cpu_idle();
        @(negedge clk);
        vec_cnt++; if (bus_req !== 1'b0) begin err_cnt++; $display("FAIL refill_gap: got %b want 0", bus_req); end
        cyc();
        bus_ack = 1'b1;
        @(negedge clk);
        vec_cnt++; if (bus_req !== 1'b1 || bus_addr !== 32'h104 || bus_wdata !== 32'hB)
            begin err_cnt++; $display("FAIL refill_drain: got req=%b %h/%h want 1 104/b", bus_req, bus_addr, bus_wdata); end
        cyc();
        cpu_idle();
        cyc();
    endtask

    // lw with ack withheld: 1 + 16 stall cycles, error data, sticky bus_err, clear
    task automatic test_timeout();
        int   stall_n = 0;
        logic early_err = 1'b0;
        logic done = 1'b0;
        cpu_rd = 1'b1; cpu_addr = 32'h80;
        for (int i = 0; i < 40 && !done; i++) begin
            if (i > 0) cyc();
            @(negedge clk);
            if (cpu_stall) begin
                stall_n++;
                if (bus_err) early_err = 1'b1;
            end else begin
                done = 1'b1;
            end
        end
        vec_cnt++; if (stall_n != 17) begin err_cnt++; $display("FAIL to_stall: got %0d want 17", stall_n); end
        vec_cnt++; if (early_err !== 1'b0) begin err_cnt++; $display("FAIL to_early_err: bus_err set while waiting"); end
        vec_cnt++; if (cpu_rdata !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL to_data: got %h want deadbeef", cpu_rdata); end
        vec_cnt++; if (bus_err !== 1'b1) begin err_cnt++; $display("FAIL to_err: got %b want 1", bus_err); end
        vec_cnt++; if (bus_req !== 1'b0) begin err_cnt++; $display("FAIL to_req: got %b want 0", bus_req); end
        cyc();
        cpu_idle();
        bus_ack = 1'b1;
        @(negedge clk);
        vec_cnt++; if (bus_req !== 1'b0 || cpu_stall !== 1'b0)
            begin err_cnt++; $display("FAIL late_ack: got req=%b stall=%b want 0 0", bus_req, cpu_stall); end
        cyc();
        bus_ack = 1'b0; err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        @(negedge clk);
        vec_cnt++; if (bus_err !== 1'b0) begin err_cnt++; $display("FAIL to_clr: got %b want 0", bus_err); end
        cyc();
    endtask

    // Misaligned accesses and err_clr vs. same-cycle new error
    task automatic test_align();
        cpu_rd = 1'b1; cpu_addr = 32'h13;
        @(negedge clk);
        vec_cnt++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h0)
            begin err_cnt++; $display("FAIL al_rd: got stall=%b data=%h want 0 0", cpu_stall, cpu_rdata); end
        cyc();
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 32'h22; cpu_wdata = 32'h99;
        @(negedge clk);
        vec_cnt++; if (align_err !== 1'b1) begin err_cnt++; $display("FAIL al_flag: got %b want 1", align_err); end
        cyc();
        cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 32'h31; err_clr = 1'b1;
        @(negedge clk);
        vec_cnt++; if (bus_req !== 1'b0) begin err_cnt++; $display("FAIL al_no_req: got %b want 0", bus_req); end
        cyc();
        cpu_rd = 1'b0;
        @(negedge clk);
        vec_cnt++; if (align_err !== 1'b1) begin err_cnt++; $display("FAIL al_set_wins: got %b want 1", align_err); end
        cyc();
        err_clr = 1'b0;
        @(negedge clk);
        vec_cnt++; if (align_err !== 1'b0) begin err_cnt++; $display("FAIL al_clr: got %b want 0", align_err); end
        cyc();
    endtask

    // Reset mid-RD drops req at once; reset mid-WR loses the buffered write
    task automatic test_async_reset();
        cpu_rd = 1'b1; cpu_addr = 32'h20;
        cyc();
        @(negedge clk);
        vec_cnt++; if (bus_req !== 1'b1) begin err_cnt++; $display("FAIL ar_req_pre: got %b want 1", bus_req); end
        rst = 1'b0;
        #1;
        vec_cnt++; if (bus_req !== 1'b0) begin err_cnt++; $display("FAIL ar_req_drop: got %b want 0", bus_req); end
        cpu_rd = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        cpu_wr = 1'b1; cpu_addr = 32'h70; cpu_wdata = 32'h77;
        cyc();
        cpu_wr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        cpu_rd = 1'b1;
        #1;
        vec_cnt++; if (cpu_stall !== 1'b1) begin err_cnt++; $display("FAIL ar_wbuf_lost: got stall=%b want 1", cpu_stall); end
        cpu_rd = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        @(negedge clk);
        vec_cnt++; if (bus_req !== 1'b0) begin err_cnt++; $display("FAIL ar_idle: got %b want 0", bus_req); end
    endtask

    initial begin
        test_reset();
        test_posted_write();
        test_read_wait();
        test_wbuf_hit();
        test_back_to_back();
        test_full_refill();
        test_timeout();
        test_align();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
